// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// MULDIV_FAST_MULT_EN selects a single-cycle multiply in the consumers of this package.
package muldiv_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   localparam int unsigned MULDIV_ITERS = 32;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Shift-add / restoring-divide datapath with magnitude operands and sign fix-up.
// With MULDIV_FAST_MULT_EN defined the product comes from a combinational multiplier.
module muldiv_core
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MULDIV_ITERS
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res_hi_o,
   output logic [WIDTH-1:0] res_lo_o,
   output logic             div_zero_o
);

   localparam int unsigned PW = 2 * WIDTH;

   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic             is_div_q, is_div_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dz_q, dz_d;

   logic             neg_a, neg_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] rem_diff;
   logic             rem_ge;
   logic [PW-1:0]    prod_raw, prod;
   logic [WIDTH-1:0] quo, rem;

   always_comb begin
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      dvs_d     = dvs_q;
      a_d       = a_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;

      neg_a = op_is_signed(op_i) & a_i[WIDTH-1];
      neg_b = op_is_signed(op_i) & b_i[WIDTH-1];

      mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, dvs_q} : '0);
      rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      rem_diff = {1'b0, rem_sh} - {2'b00, dvs_q};
      rem_ge   = ~rem_diff[WIDTH+1];

      if (load_i) begin
         // LO starts as |A| and the divisor/multiplicand register as |B| for both ops
         acc_hi_d  = '0;
         acc_lo_d  = neg_a ? -a_i : a_i;
         dvs_d     = neg_b ? -b_i : b_i;
         a_d       = a_i;
         is_div_d  = op_is_div(op_i);
         neg_res_d = neg_a ^ neg_b;
         neg_rem_d = neg_a;
         dz_d      = op_is_div(op_i) & (b_i == '0);
      end else if (step_i) begin
         if (is_div_q) begin
            acc_hi_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
         end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         dvs_q     <= '0;
         a_q       <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         dvs_q     <= dvs_d;
         a_q       <= a_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
      end
   end

   always_comb begin
`ifdef MULDIV_FAST_MULT_EN
      prod_raw = PW'(acc_lo_q) * PW'(dvs_q);
`else
      prod_raw = {acc_hi_q, acc_lo_q};
`endif
      prod = neg_res_q ? -prod_raw : prod_raw;
      quo  = neg_res_q ? -acc_lo_q : acc_lo_q;
      rem  = neg_rem_q ? -acc_hi_q : acc_hi_q;

      if (dz_q) begin
         res_hi_o = a_q;
         res_lo_o = '1;
      end else if (is_div_q) begin
         res_hi_o = rem;
         res_lo_o = quo;
      end else begin
         res_hi_o = prod[PW-1:WIDTH];
         res_lo_o = prod[WIDTH-1:0];
      end
   end

   assign div_zero_o = dz_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS-style HI/LO multiply/divide unit: FSM, iteration counter and pipeline stall.
// MULDIV_FAST_MULT_EN sends mult/multu straight to FIX using a combinational product.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MULDIV_ITERS
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   input  logic             mf_req_i,
   output logic             busy_o,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_by_zero_o
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`ifdef MULDIV_FAST_MULT_EN
   localparam state_e MUL_TARGET = S_FIX;
`else
   localparam state_e MUL_TARGET = S_MUL;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dz_q, dz_d;
   logic             accept;
   logic             step;
   logic [WIDTH-1:0] core_hi, core_lo;
   logic             core_dz;

   assign accept = start_i & ((state_q == S_IDLE) | (state_q == S_DONE));

   muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (accept),
      .step_i     (step),
      .op_i       (op_i),
      .a_i        (operand_a_i),
      .b_i        (operand_b_i),
      .res_hi_o   (core_hi),
      .res_lo_o   (core_lo),
      .div_zero_o (core_dz)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
      step    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) state_d = S_IDLE;
            if (accept) begin
               cnt_d = '0;
               dz_d  = 1'b0;
               if (op_is_div(op_i)) state_d = (operand_b_i == '0) ? S_FIX : S_DIV;
               else                 state_d = MUL_TARGET;
            end
         end
         S_MUL, S_DIV: begin
            step = 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FIX: begin
            // architectural HI/LO only ever change here
            state_d = S_DONE;
            hi_d    = core_hi;
            lo_d    = core_lo;
            dz_d    = core_dz;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
      end
   end

   assign busy_o        = (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX);
   assign done_o        = (state_q == S_DONE);
   assign stall_o       = mf_req_i & (busy_o | accept);
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;
   assign div_by_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expectations pushed at issue, popped at Done.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
   localparam int MUL_LAT = 2;
   localparam logic [1:0] ABORT_OP = OP_DIVU;
`else
   localparam int MUL_LAT = 34;
   localparam logic [1:0] ABORT_OP = OP_MULTU;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0, b = '0;
   logic         mf_req = 1'b0;
   logic         busy, stall, done, dz;
   logic [W-1:0] hi, lo;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
      .operand_a_i(a), .operand_b_i(b), .mf_req_i(mf_req),
      .busy_o(busy), .stall_o(stall), .done_o(done),
      .hi_o(hi), .lo_o(lo), .div_by_zero_o(dz)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_done = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done === 1'b1) n_done <= n_done + 1;

   int n_cmp = 0, n_err = 0, n_acc = 0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           due;
   } exp_t;
   exp_t sb[$];

   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int n);
      exp_t e;
      logic signed [63:0] sx, sy, sp, q, r;
      logic [63:0] up;
      e.dz = 1'b0;
      e.due = n + MUL_LAT;
      sx = $signed({{32{x[31]}}, x});
      sy = $signed({{32{y[31]}}, y});
      case (o)
         OP_MULT:  begin sp = sx * sy; e.hi = sp[63:32]; e.lo = sp[31:0]; end
         OP_MULTU: begin up = {32'b0, x} * {32'b0, y}; e.hi = up[63:32]; e.lo = up[31:0]; end
         default: begin
            if (y == '0) begin
               e.hi = x; e.lo = '1; e.dz = 1'b1; e.due = n + 2;
            end else begin
               e.due = n + 34;
               if (o == OP_DIV) begin
                  q = sx / sy; r = sx % sy;
                  e.lo = q[31:0]; e.hi = r[31:0];
               end else begin
                  e.lo = x / y; e.hi = x % y;
               end
            end
         end
      endcase
      return e;
   endfunction

   // caller is mid-cycle; Start is held for this cycle only
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit track);
      start = 1'b1; op = o; a = x; b = y;
      if (track) begin
         sb.push_back(model(o, x, y, cyc));
         n_acc++;
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic collect(output logic [W-1:0] h, output logic [W-1:0] l, output logic z,
                          output int c, output bit ok);
      ok = 1'b0; h = '0; l = '0; z = 1'b0; c = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            h = hi; l = lo; z = dz; c = cyc; ok = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      // Start held high throughout reset must not be accepted
      rst = 1'b1; start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5;
      repeat (3) @(posedge clk);
      #1; start = 1'b0; rst = 1'b0; mf_req = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", stall); end
      n_cmp++; if (hi !== '0) begin n_err++; $display("FAIL reset_hi got %h exp 0", hi); end
      n_cmp++; if (lo !== '0) begin n_err++; $display("FAIL reset_lo got %h exp 0", lo); end
      n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL reset_dz got %b exp 0", dz); end
      @(posedge clk); #1; mf_req = 1'b0;
   endtask

   task automatic test_vectors;
      logic [1:0]   t_op [8] = '{OP_MULTU, OP_MULT, OP_DIV, OP_DIV, OP_DIVU, OP_MULT, OP_DIV, OP_DIVU};
      logic [W-1:0] t_a  [8] = '{32'hFFFFFFFF, -32'sd7, -32'sd7, 32'h80000000, 32'd7, 32'h80000000, 32'd7, 32'hFFFFFFFF};
      logic [W-1:0] t_b  [8] = '{32'hFFFFFFFF, 32'd3, 32'd2, 32'hFFFFFFFF, 32'd0, 32'h80000000, -32'sd2, 32'd1};
      logic [W-1:0] h, l;
      logic z;
      int c;
      bit ok;
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         issue(t_op[i], t_a[i], t_b[i], 1'b1);
         collect(h, l, z, c, ok);
         e = sb.pop_front();
         n_cmp++; if (!ok) begin n_err++; $display("FAIL vec%0d_timeout no Done within bound", i); end
         n_cmp++; if (l !== e.lo) begin n_err++; $display("FAIL vec%0d_lo got %h exp %h", i, l, e.lo); end
         n_cmp++; if (h !== e.hi) begin n_err++; $display("FAIL vec%0d_hi got %h exp %h", i, h, e.hi); end
         n_cmp++; if (z !== e.dz) begin n_err++; $display("FAIL vec%0d_dz got %b exp %b", i, z, e.dz); end
         n_cmp++; if (c !== e.due) begin n_err++; $display("FAIL vec%0d_latency done cycle %0d exp %0d", i, c, e.due); end
         @(posedge clk); #1;
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL vec%0d_single_pulse done %b exp 0", i, done); end
      end
   endtask

   task automatic test_div_by_zero_sticky;
      logic [W-1:0] h, l;
      logic z;
      int c;
      bit ok;
      exp_t e;
      @(posedge clk); #1;
      issue(OP_DIVU, 32'd7, 32'd0, 1'b1);
      collect(h, l, z, c, ok);
      e = sb.pop_front();
      n_cmp++; if (!ok || c !== e.due) begin n_err++; $display("FAIL dz_latency done cycle %0d exp %0d", c, e.due); end
      n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL dz_flag got %b exp 1", z); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (dz !== 1'b1) begin n_err++; $display("FAIL dz_sticky got %b exp 1", dz); end
      issue(OP_MULT, 32'd2, 32'd3, 1'b1);
      @(negedge clk);
      n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL dz_clear_on_start got %b exp 0", dz); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL dz_next_busy got %b exp 1", busy); end
      collect(h, l, z, c, ok);
      e = sb.pop_front();
      n_cmp++; if (!ok || l !== e.lo || h !== e.hi) begin n_err++; $display("FAIL dz_next_result got %h_%h exp %h_%h", h, l, e.hi, e.lo); end
   endtask

   task automatic test_stall;
      logic [W-1:0] hi_prev, lo_prev;
      exp_t e;
      logic exp_stall;
      @(posedge clk); #1;
      for (int k = 0; k <= 34; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         mf_req = 1'b1;
         start  = (k == 0) || (k == 5);
         if (k == 0) begin
            op = OP_DIV; a = 32'd1000; b = 32'd7;
            sb.push_back(model(OP_DIV, 32'd1000, 32'd7, cyc));
            n_acc++;
         end
         if (k == 5) begin op = OP_MULTU; a = 32'd3; b = 32'd5; end
         @(negedge clk);
         exp_stall = (k <= 33);
         n_cmp++; if (stall !== exp_stall) begin n_err++; $display("FAIL stall_k%0d got %b exp %b", k, stall, exp_stall); end
         if (k == 0) begin hi_prev = hi; lo_prev = lo; end
         if (k == 20) begin
            n_cmp++; if (hi !== hi_prev || lo !== lo_prev) begin n_err++; $display("FAIL hilo_hold got %h_%h exp %h_%h", hi, lo, hi_prev, lo_prev); end
         end
         if (k == 34) begin
            e = sb.pop_front();
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_div_done got %b exp 1", done); end
            n_cmp++; if (lo !== e.lo || hi !== e.hi) begin n_err++; $display("FAIL stall_div_result got %h_%h exp %h_%h", hi, lo, e.hi, e.lo); end
         end
      end
      @(posedge clk); #1;
      mf_req = 1'b0; start = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignored_start_busy got %b exp 0", busy); end
   endtask

   task automatic test_reset_mid;
      logic [W-1:0] h, l;
      logic z;
      int c;
      bit ok;
      exp_t e;
      @(posedge clk); #1;
      issue(ABORT_OP, 32'd123456, 32'd789, 1'b0);
      repeat (9) @(posedge clk);
      #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", busy); end
      n_cmp++; if (hi !== '0 || lo !== '0) begin n_err++; $display("FAIL midrst_hilo got %h_%h exp 0_0", hi, lo); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b exp 0", done); end
      @(posedge clk); #1;
      issue(OP_MULTU, 32'd6, 32'd7, 1'b1);
      collect(h, l, z, c, ok);
      e = sb.pop_front();
      n_cmp++; if (!ok || c !== e.due) begin n_err++; $display("FAIL midrst_latency done cycle %0d exp %0d", c, e.due); end
      n_cmp++; if (l !== e.lo || h !== e.hi) begin n_err++; $display("FAIL midrst_result got %h_%h exp %h_%h", h, l, e.hi, e.lo); end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] h, l, x, y;
      logic [1:0] o;
      logic z;
      int c;
      bit ok;
      exp_t e;
      @(posedge clk); #1;
      issue(OP_DIVU, 32'd100, 32'd9, 1'b1);
      for (int i = 0; i < 6; i++) begin
         collect(h, l, z, c, ok);
         e = sb.pop_front();
         n_cmp++; if (!ok || c !== e.due) begin n_err++; $display("FAIL b2b%0d_latency done cycle %0d exp %0d", i, c, e.due); end
         n_cmp++; if (l !== e.lo || h !== e.hi || z !== e.dz) begin n_err++; $display("FAIL b2b%0d_result got %h_%h dz%b exp %h_%h dz%b", i, h, l, z, e.hi, e.lo, e.dz); end
         if (i < 5) begin
            // issue in the DONE cycle itself
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = (i == 2) ? 32'd0 : (o[1] ? 32'($urandom_range(1, 1000)) : $urandom);
            issue(o, x, y, 1'b1);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_div_by_zero_sticky();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (n_done !== n_acc) begin n_err++; $display("FAIL done_count got %0d exp %0d", n_done, n_acc); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  EX-stage mult/div issue strobe, one cycle.
REQ-005 Op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 OperandA  input  WIDTH  multiplicand or dividend (rs).
REQ-007 OperandB  input  WIDTH  multiplier or divisor (rt).
REQ-008 MfReq  input  1  ID-stage instruction is mfhi or mflo.
REQ-009 Busy  output  1  operation in flight.
REQ-010 Stall  output  1  freeze PC and IF/ID, and bubble ID/EX.
REQ-011 Done  output  1  one-cycle completion pulse.
REQ-012 HI  output  WIDTH  product high word or remainder.
REQ-013 LO  output  WIDTH  product low word or quotient.
REQ-014 DivByZero  output  1  last divide had OperandB==0; sticky until next accepted Start.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, DIV, FIX and DONE; Busy=1 exactly in MUL, DIV and FIX.
REQ-016 Start SHALL be accepted only in IDLE or DONE; Op and operands are latched at the accepting edge N; Start in MUL, DIV or FIX is ignored.
REQ-017 Accepted mult/multu SHALL go to MUL; div/divu with OperandB!=0 SHALL go to DIV; div/divu with OperandB==0 SHALL go directly to FIX.
REQ-018 MUL and DIV SHALL each last exactly WIDTH cycles, counted by a 0..WIDTH-1 counter, performing one shift-add or one restoring-subtract step per cycle; the state then goes to FIX.
REQ-019 FIX SHALL apply sign correction and write HI/LO; the next state SHALL be DONE, which lasts one cycle (Done=1) and then returns to IDLE unless a new Start is accepted.
REQ-020 Iterative latency: Start at edge N gives Busy high for cycles N+1..N+33 and Done high in cycle N+34; HI/LO are updated at edge N+33.
REQ-021 Signed operations SHALL operate on magnitudes:
- product negated when signA^signB
- quotient negated when signA^signB
- remainder takes the sign of OperandA
REQ-022 Edge case 0x80000000 / -1 SHALL give LO=0x80000000, HI=0.
REQ-023 Divide by zero SHALL give LO=all ones, HI=OperandA, DivByZero=1, with Done in cycle N+2.
REQ-024 Stall SHALL be combinational: MfReq & (Busy | Start accepted this cycle).
REQ-025 HI and LO SHALL change only at the FIX-to-DONE edge; they hold their values at all other times.

Reset
REQ-026 Reset SHALL force state IDLE, counter=0, HI=0, LO=0, Busy=0, Done=0, Stall=0 and DivByZero=0 at the next edge, including mid-operation; the in-flight result is discarded.
REQ-027 Reset SHALL take priority over a simultaneous Start.

Configuration
REQ-028 Macro MULDIV_FAST_MULT_EN: when defined, mult/multu SHALL use a single-cycle combinational multiply, go IDLE->FIX directly, and give Done in cycle N+2.
REQ-029 When MULDIV_FAST_MULT_EN is undefined, the multiply SHALL be iterative per REQ-018; divide behaviour is identical in both builds.

Structure
REQ-030 Shared package/header muldiv_pkg SHALL hold:
- state encodings
- Op codes (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
- iteration count constant
REQ-031 The shift/add/subtract datapath SHALL be a sub-module muldiv_core, with FSM and counter owned by muldiv_sequencer.

Verification
REQ-032 multu with A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, Done in cycle N+34 (N+2 with fast build).
REQ-033 mult with A=-7, B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-034 div with A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=0 -> LO=0xFFFFFFFF, HI=7, DivByZero=1, Done in cycle N+2.
REQ-035 MfReq held from cycle N through N+34 with div started at N -> Stall=1 through N+33 and 0 in N+34; second Start at N+5 is ignored.
REQ-036 Reset asserted at N+10 of a multu -> IDLE, HI=LO=0, no Done pulse; a new Start at N+12 completes normally.
REQ-037 Back-to-back: Start in the DONE cycle is accepted; Done pulses exactly once per accepted operation.
